// File: rtl/rx_deframer.sv
// QPSK frame synchronizer: hunts for SYNC_WORD, reads an 8-bit length, packs payload symbols
// into bytes and delivers them through a FIFO as an AXI-Stream byte stream. Optional: RX_DEFRAMER_INV_EN.
module rx_deframer #(
    parameter logic [31:0] SYNC_WORD  = 32'h1ACFFC1D,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [1:0] in_data,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       locked,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {HUNT, LEN, PAYLOAD} state_t;

    state_t      state_q, state_d;
    logic [29:0] sr_q, sr_d;
    logic [1:0]  sym_cnt_q, sym_cnt_d;
    logic [5:0]  acc_q, acc_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic        locked_q, locked_d;
    logic        ovf_q, ovf_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   count_q, count_d;
    logic [8:0]    mem_q [FIFO_DEPTH];
`ifdef RX_DEFRAMER_INV_EN
    logic        inv_q, inv_d;
`endif

    logic [31:0] sr_win;
    logic [1:0]  sym;
    logic [7:0]  byte_w;
    logic        pop, can_push, push, push_last;

    always_comb begin
        // Only 30 history bits are stored; the newest symbol completes the 32-bit window.
        sr_win     = {sr_q, in_data};
`ifdef RX_DEFRAMER_INV_EN
        sym        = in_data ^ {2{inv_q}};
        inv_d      = inv_q;
`else
        sym        = in_data;
`endif
        byte_w     = {acc_q, sym};
        pop        = out_valid && out_ready;
        can_push   = (count_q != DEPTH_C) || pop;
        push       = 1'b0;
        push_last  = 1'b0;
        state_d    = state_q;
        sr_d       = sr_q;
        sym_cnt_d  = sym_cnt_q;
        acc_d      = acc_q;
        byte_cnt_d = byte_cnt_q;
        ovf_d      = ovf_q;

        if (in_valid) begin
            sr_d = sr_win[29:0];
            unique case (state_q)
                HUNT: begin
                    if (sr_win == SYNC_WORD) begin
                        state_d   = LEN;
                        sym_cnt_d = 2'd0;
                    end
`ifdef RX_DEFRAMER_INV_EN
                    else if (sr_win == ~SYNC_WORD) begin
                        state_d   = LEN;
                        sym_cnt_d = 2'd0;
                        inv_d     = 1'b1;
                    end
`endif
                end
                LEN: begin
                    acc_d     = byte_w[5:0];
                    sym_cnt_d = sym_cnt_q + 2'd1;
                    if (sym_cnt_q == 2'd3) begin
                        if (byte_w == 8'd0) begin
                            state_d = HUNT;
`ifdef RX_DEFRAMER_INV_EN
                            inv_d   = 1'b0;
`endif
                        end else begin
                            byte_cnt_d = byte_w;
                            state_d    = PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    acc_d     = byte_w[5:0];
                    sym_cnt_d = sym_cnt_q + 2'd1;
                    if (sym_cnt_q == 2'd3) begin
                        if (can_push) begin
                            push       = 1'b1;
                            push_last  = (byte_cnt_q == 8'd1);
                            byte_cnt_d = byte_cnt_q - 8'd1;
                            if (byte_cnt_q == 8'd1) state_d = HUNT;
                        end else begin
                            // Refused byte: abandon the frame, it will never see TLAST.
                            ovf_d   = 1'b1;
                            state_d = HUNT;
                        end
`ifdef RX_DEFRAMER_INV_EN
                        if (state_d == HUNT) inv_d = 1'b0;
`endif
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        locked_d = (state_d != HUNT);
        wr_d     = push ? wr_q + 1'b1 : wr_q;
        rd_d     = pop  ? rd_q + 1'b1 : rd_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HUNT;
            sr_q       <= '0;
            sym_cnt_q  <= '0;
            acc_q      <= '0;
            byte_cnt_q <= '0;
            locked_q   <= 1'b0;
            ovf_q      <= 1'b0;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
`ifdef RX_DEFRAMER_INV_EN
            inv_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            sym_cnt_q  <= sym_cnt_d;
            acc_q      <= acc_d;
            byte_cnt_q <= byte_cnt_d;
            locked_q   <= locked_d;
            ovf_q      <= ovf_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
`ifdef RX_DEFRAMER_INV_EN
            inv_q      <= inv_d;
`endif
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {push_last, byte_w};
    end

    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_q[rd_q][7:0] : 8'd0;
    assign out_last  = out_valid && mem_q[rd_q][8];
    assign locked    = locked_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_rx_deframer.sv
// Bench for rx_deframer: frame-level reference model with per-cycle comparison plus directed literal checks.
module tb_rx_deframer;

    localparam logic [31:0] SYNC  = 32'h1ACFFC1D;
    localparam int          DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [1:0] in_data = 2'b00;
    logic       out_valid, out_last, out_ready, locked, overflow;
    logic [7:0] out_data;

    rx_deframer #(.SYNC_WORD(SYNC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .locked(locked), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame-level) ----------------
    logic [8:0]  mq[$];
    logic [31:0] hist;
    int          phase, nsym, acc, remaining;
    bit          m_inv, m_ovf, m_locked, m_pop, m_room;
    logic [1:0]  s;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            hist = 0; phase = 0; nsym = 0; acc = 0; remaining = 0;
            m_inv = 0; m_ovf = 0; m_locked = 0;
        end else begin
            m_pop  = (mq.size() != 0) && out_ready;
            m_room = (mq.size() < DEPTH) || m_pop;
            if (m_pop) mq.delete(0);
            if (in_valid) begin
                hist = {hist[29:0], in_data};
                s = in_data ^ (m_inv ? 2'b11 : 2'b00);
                if (phase == 0) begin
                    if (hist == SYNC) begin
                        phase = 1; nsym = 0; acc = 0;
                    end
`ifdef RX_DEFRAMER_INV_EN
                    else if (hist == ~SYNC) begin
                        phase = 1; nsym = 0; acc = 0; m_inv = 1;
                    end
`endif
                end else begin
                    acc = acc * 4 + int'(s);
                    nsym++;
                    if (nsym == 4) begin
                        if (phase == 1) begin
                            if (acc == 0) phase = 0;
                            else begin remaining = acc; phase = 2; end
                        end else if (m_room) begin
                            mq.push_back({remaining == 1, acc[7:0]});
                            remaining--;
                            if (remaining == 0) phase = 0;
                        end else begin
                            m_ovf = 1; phase = 0;
                        end
                        acc = 0; nsym = 0;
                        if (phase == 0) m_inv = 0;
                    end
                end
            end
            m_locked = (phase != 0);
        end
    end

    // ---------------- per-cycle compare ----------------
    bit         run_cmp = 0;
    bit         stall, was_rst;
    logic [7:0] held_d;
    logic       held_l;

    initial forever begin
        @(posedge clk);
        stall   = out_valid && !out_ready;
        held_d  = out_data;
        held_l  = out_last;
        was_rst = rst;
        @(negedge clk);
        if (run_cmp) begin
            chk("out_valid", int'(out_valid), int'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("out_data", int'(out_data), int'(mq[0][7:0]));
                chk("out_last", int'(out_last), int'(mq[0][8]));
            end
            chk("locked", int'(locked), int'(m_locked));
            chk("overflow", int'(overflow), int'(m_ovf));
            if (stall && !was_rst) begin
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_data", int'(out_data), int'(held_d));
                chk("stall_last", int'(out_last), int'(held_l));
            end
        end
    end

    // ---------------- output capture ----------------
    logic [8:0] cap[$];
    always @(posedge clk)
        if (!rst && out_valid && out_ready) cap.push_back({out_last, out_data});

    // ---------------- out_ready driver ----------------
    int rdy_mode = 0;  // 0: always ready, 1: never ready, 2: random
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    bit gap_en = 0;

    task automatic send_sym(input logic [1:0] v);
        if (gap_en) begin
            while ($urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                in_data  = 2'($urandom_range(0, 3));
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 3; i >= 0; i--) send_sym(b[2*i +: 2]);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 15; i >= 0; i--) send_sym(w[2*i +: 2]);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_drain();
        in_valid = 1'b0;
        for (int i = 0; i < 400 && (out_valid || mq.size() != 0); i++) @(negedge clk);
        chk("drain_timeout", int'(out_valid), 0);
    endtask

    task automatic chk_frame1(input string nm);
        chk({nm, "_count"}, cap.size(), 3);
        if (cap.size() == 3) begin
            chk({nm, "_b0"}, int'(cap[0]), 9'h0A5);
            chk({nm, "_b1"}, int'(cap[1]), 9'h03C);
            chk({nm, "_b2"}, int'(cap[2]), 9'h1FF);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_overflow", int'(overflow), 0);
        run_cmp = 1;

        // Test 1: basic 3-byte frame.
        cap.delete();
        send_word(SYNC);
        chk("t1_locked_after_sync", int'(locked), 1);
        send_byte(8'h03);
        send_byte(8'hA5);
        send_byte(8'h3C);
        send_byte(8'hFF);
        chk("t1_ff_valid_next", int'(out_valid), 1);
        chk("t1_ff_data_next", int'(out_data), 8'hFF);
        chk("t1_ff_last_next", int'(out_last), 1);
        chk("t1_unlock", int'(locked), 0);
        idle(4);
        chk_frame1("t1");

        // Test 2: zero-length frame, then a normal one.
        cap.delete();
        send_word(SYNC);
        send_sym(2'b00); send_sym(2'b00); send_sym(2'b00);
        chk("t2_locked_in_len", int'(locked), 1);
        send_sym(2'b00);
        chk("t2_unlock", int'(locked), 0);
        idle(4);
        chk("t2_no_output", cap.size(), 0);
        send_word(SYNC);
        send_byte(8'h03); send_byte(8'hA5); send_byte(8'h3C); send_byte(8'hFF);
        wait_drain();
        chk_frame1("t2");

        // Test 3: random gaps on input and random stalls on output.
        cap.delete();
        gap_en   = 1;
        rdy_mode = 2;
        send_word(SYNC);
        send_byte(8'h03); send_byte(8'hA5); send_byte(8'h3C); send_byte(8'hFF);
        wait_drain();
        gap_en   = 0;
        rdy_mode = 0;
        idle(2);
        chk_frame1("t3");

        // Test 5: inverted marker and inverted frame contents.
        cap.delete();
        send_word(~SYNC);
`ifdef RX_DEFRAMER_INV_EN
        chk("t5_locked", int'(locked), 1);
`else
        chk("t5_locked", int'(locked), 0);
`endif
        send_byte(~8'h03); send_byte(~8'hA5); send_byte(~8'h3C); send_byte(~8'hFF);
        wait_drain();
        idle(2);
`ifdef RX_DEFRAMER_INV_EN
        chk_frame1("t5");
`else
        chk("t5_no_output", cap.size(), 0);
`endif

        // Test 4: overflow with a stalled sink.
        cap.delete();
        rdy_mode = 1;
        @(negedge clk);
        send_word(SYNC);
        send_byte(8'd20);
        for (int i = 0; i < 17; i++) send_byte(8'h10 + 8'(i));
        chk("t4_overflow", int'(overflow), 1);
        chk("t4_unlock", int'(locked), 0);
        for (int i = 17; i < 20; i++) send_byte(8'h10 + 8'(i));
        rdy_mode = 0;
        wait_drain();
        idle(2);
        chk("t4_count", cap.size(), 16);
        n = (cap.size() < 16) ? cap.size() : 16;
        for (int i = 0; i < n; i++)
            chk("t4_byte", int'(cap[i]), int'({1'b0, 8'h10 + 8'(i)}));
        chk("t4_overflow_sticky", int'(overflow), 1);

        // Test 6: reset mid-frame with bytes queued.
        cap.delete();
        rdy_mode = 1;
        @(negedge clk);
        send_word(SYNC);
        send_byte(8'd10);
        send_byte(8'h01);
        send_byte(8'h02);
        chk("t6_queued", int'(out_valid), 1);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_valid", int'(out_valid), 0);
        chk("t6_rst_data", int'(out_data), 0);
        chk("t6_rst_last", int'(out_last), 0);
        chk("t6_rst_locked", int'(locked), 0);
        chk("t6_rst_overflow", int'(overflow), 0);
        rdy_mode = 0;
        for (int i = 2; i < 10; i++) send_byte(8'h01 + 8'(i));
        idle(6);
        chk("t6_no_output", cap.size(), 0);

        run_cmp = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rx_deframer.md
# rx_deframer

Frame synchronizer and byte packer that sits directly downstream of the physical receiver in the RX path. Consumes the receiver's 2-bit hard-decision QPSK symbol stream (which has no backpressure) and hunts for a 32-bit attached sync marker. On a match it reads an 8-bit length field, then packs the payload symbols into bytes. Bytes are buffered in a small FIFO and presented as an AXI-Stream byte stream with TLAST on the final byte of each frame.

## Interface
- `SYNC_WORD`, 32'h1ACFFC1D: sync marker, MSB received first; must be nonzero.
- `FIFO_DEPTH`, 16: output FIFO depth in bytes; power of two, ≥2.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  symbol strobe from the physical receiver.
- `in_data`  in  2  symbol; [1]=I bit, [0]=Q bit.
- `out_valid`  out  1  AXIS TVALID.
- `out_data`  out  8  AXIS TDATA.
- `out_last`  out  1  AXIS TLAST, high on the final payload byte.
- `out_ready`  in  1  AXIS TREADY.
- `locked`  out  1  high while in LEN or PAYLOAD.
- `overflow`  out  1  sticky FIFO-overflow flag; cleared only by `rst`.

## Operation
- The 32-bit shift register `sr` updates on each `in_valid` beat: `sr <= {sr[29:0], in_data}`. It is reset to 0.
- Symbol-to-byte packing: the first symbol of a byte fills [7:6], the fourth fills [1:0].
- FSM states: HUNT, LEN, PAYLOAD.
  - **HUNT:** on a valid beat where `{sr[29:0],in_data} == SYNC_WORD`, go to LEN and clear the symbol counter.
  - **LEN:** collect 4 symbols into `len[7:0]`.
    - `len==0`: return to HUNT with no output.
    - Otherwise load the byte counter with `len` and go to PAYLOAD.
  - **PAYLOAD:** each 4th symbol completes a byte, which is pushed to the FIFO with `last = (byte counter == 1)`.
    - After the last byte, go to HUNT.
    - `sr` continues shifting in all states, so a marker may begin immediately after a frame.
- `in_valid` low cycles are ignored and no state advances.
- FIFO push is allowed when `!full || (out_valid && out_ready)`. Simultaneous push and pop while full is accepted.
- Overflow (push refused):
  - The byte is dropped, `overflow` is set, and the FSM returns to HUNT.
  - The truncated frame carries no `out_last`. Bytes already queued are still delivered.
- The FIFO pops on `out_valid && out_ready`. `out_data`/`out_last` must hold stable while `out_valid && !out_ready`.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_last`=0, `locked`=0, `overflow`=0. After reset the FIFO is empty, the FSM is in HUNT, and all counters are 0.
- `locked` rises the cycle after the matching sync beat. It falls the cycle after the final payload byte is pushed, after a zero-length field, or after an overflow.
- Latency: a byte completed on a beat at cycle t appears on `out_valid`/`out_data` at cycle t+1 if the FIFO was empty.
- Throughput: up to 1 byte per 4 `in_valid` beats in, and 1 byte/cycle out.
- A `rst` asserted mid-frame takes effect at the next edge. The FIFO is flushed, so no partial frame survives, and `overflow` is cleared.
- No combinational path from `in_*` to `out_*`.

## Configuration
- `RX_DEFRAMER_INV_EN` defined:
  - HUNT also matches `~SYNC_WORD` (180° QPSK phase ambiguity).
  - On an inverted match, an `inv` flag is set and every subsequent LEN/PAYLOAD symbol is bit-inverted before use until the frame ends.
  - `inv` is cleared on return to HUNT and on reset.
- Undefined: only a true `SYNC_WORD` match locks; no inversion logic is present.

## Test plan
1. Send the sync word, `len`=3, payload A5 3C FF, with `out_ready`=1.
   - Expect exactly 3 beats: A5, 3C, FF, with `out_last` only on FF.
   - `locked` is high from the cycle after sync until FF is pushed.
   - FF appears 1 cycle after its 4th symbol.
2. Send the sync word then `len`=00.
   - Expect no output, `locked` high for the 4 LEN beats then low.
   - A following valid frame must then be received correctly.
3. Repeat test 1 with `in_valid` toggled randomly at ~50% and `out_ready` randomly stalled.
   - Expect an identical byte sequence.
   - `out_data` must be stable during every stall.
4. With `FIFO_DEPTH`=16 and `out_ready`=0, send a 20-byte frame, then raise `out_ready`.
   - Expect `overflow`=1 after the 17th byte completes and `locked`=0.
   - Then 16 bytes drain with no `out_last`, and `overflow` stays 1 until `rst`.
5. Send `~SYNC_WORD`, `~03`, `~A5 ~3C ~FF`.
   - With `RX_DEFRAMER_INV_EN`: output identical to test 1.
   - Without it: no lock and no output.
6. Assert `rst` for one cycle after the 2nd payload byte of a 10-byte frame.
   - The next cycle must show all outputs at reset values and the FIFO empty.
   - The remaining symbols of that frame must produce no output.
